// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared types and constants for the 4:1 mux round-robin scheduler.
// Select index i drives the mux as s0=i[1], s1=i[0].
package mux4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Requester/mux-select bundle between the four requesters and the scheduler.
interface mux4_rr_scheduler_if;

    logic [3:0] req;
    logic [3:0] gnt;
    logic       s0;
    logic       s1;
    logic       sel_valid;
    logic [1:0] owner;

    modport master (
        output req,
        input  gnt,
        input  s0,
        input  s1,
        input  sel_valid,
        input  owner
    );

    modport slave (
        input  req,
        output gnt,
        output s0,
        output s1,
        output sel_valid,
        output owner
    );

endinterface

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// Combinational round-robin picker: first set bit of req scanning up from ptr,
// wrapping 3->0.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner scheduler for the shared 4:1 mux: bounded tenure under
// contention and a break-before-make dead gap on every owner change.
module mux4_rr_scheduler
    import mux4_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux4_rr_scheduler_if.slave   bus
);

    localparam int unsigned     HW        = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam int unsigned     GW        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]   GAP_LOAD  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam bit              NO_GAP    = (GAP_CYCLES == 0);

    sched_state_t  state;
    logic [1:0]    ptr;
    logic [1:0]    owner_q;
    logic [HW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    gnt_q;
    logic          s0_q;
    logic          s1_q;
    logic          valid_q;

    logic          pick_any;
    logic [1:0]    pick_idx;
    logic          others_wait;
    logic          release_now;
    logic          take;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // All three grant opportunities share one picker; take marks the edge that
    // installs a new owner so the grant assignments live in one place.
    always_comb begin
        others_wait = (bus.req & ~onehot4(owner_q)) != 4'b0000;
        release_now = !bus.req[owner_q] || ((hold_cnt == HOLD_LAST) && others_wait);
        take        = 1'b0;
        case (state)
            IDLE:    take = pick_any;
            GRANT:   take = release_now && NO_GAP && pick_any;
            GAP:     take = (gap_cnt == '0) && pick_any;
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= SEL_A;
            owner_q  <= SEL_A;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            gnt_q    <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else if (take) begin
            state    <= GRANT;
            gnt_q    <= onehot4(pick_idx);
            s0_q     <= pick_idx[1];
            s1_q     <= pick_idx[0];
            owner_q  <= pick_idx;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
            ptr      <= pick_idx + 2'd1;
        end else begin
            case (state)
                IDLE: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
                GRANT: begin
                    if (release_now) begin
                        gnt_q   <= '0;
                        valid_q <= 1'b0;
                        if (NO_GAP) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.s0        = s0_q;
    assign bus.s1        = s1_q;
    assign bus.sel_valid = valid_q;
    assign bus.owner     = owner_q;

endmodule
